mem_stall_ctrl: RTL and testbench
=================================

Name: mem_stall_ctrl

Overview:
- Multi-cycle data-memory access controller in the MEM stage.
- Takes MemRead/MemWrite, address and store data from EX/MEM, and runs a req/ack handshake to the data memory.
- Returns load data to MEM/WB.
- Generates the stall signal consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, which freezes the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM
- addr_i  in  ADDR_W  ALU result (byte address)
- wdata_i  in  DATA_W  store data (RS2data)
- rdata_o  out  DATA_W  load data to MEM/WB
- stall_o  out  1  pipeline stall, drives stall_i of all pipeline registers
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  1 = write, 0 = read, registered
- mem_addr_o  out  ADDR_W  registered request address
- mem_wdata_o  out  DATA_W  registered write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1
- err_o  out  1  sticky timeout error

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o all 0.
  - stall_o=0.
  - Reset asserted mid-access abandons the request: mem_req_o drops immediately and no ack is awaited after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - acc = MemRead_i | MemWrite_i.
  - stall_o = acc (combinational, same cycle, so EX/MEM holds the instruction at the next edge).
  - On an edge with acc=1: capture addr_i, wdata_i, mem_we_o=MemWrite_i; set mem_req_o=1; go to BUSY.
  - If MemRead_i and MemWrite_i are both 1, the write wins.
- BUSY:
  - stall_o=1; mem_req_o and the address/data/we outputs are held stable.
  - On an edge with mem_ack_i=1: mem_req_o=0; if mem_we_o=0, rdata_o<=mem_rdata_i; go to DONE.
- DONE:
  - stall_o=0 for exactly one cycle, so the pipeline advances past the access.
  - MemRead_i/MemWrite_i are ignored in this state; the same instruction is still visible and must not re-issue.
  - Next edge: go to IDLE.
- mem_ack_i outside BUSY is ignored.
- Latency: with the request seen in cycle 0 and ack in cycle k (k≥1), stall_o is high in cycles 0..k and low in cycle k+1 (DONE). The minimum access therefore costs 2 stall cycles.
- rdata_o holds the last completed load value until the next load completes; stores do not change it.
- Back-to-back accesses: the next access is accepted in IDLE the cycle after DONE, with no bubble beyond DONE.
- The stall_o path is combinational from MemRead_i/MemWrite_i only in IDLE; it is registered-state-based otherwise.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter (width ceil(log2(TIMEOUT+1))) clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with no ack: mem_req_o=0; err_o=1, sticky until reset; for a read, rdata_o=DATA_W'hDEADBEEF (truncated/zero-extended to DATA_W); go to DONE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; err_o is tied 0.

Test Plan:
- Load, memory acks 3 cycles after req (addr_i=0x40, mem_rdata_i=0x12345678) -> stall_o high for 4 cycles, then low for 1; rdata_o=0x12345678; mem_we_o=0; mem_addr_o=0x40 throughout BUSY.
- Store, immediate ack (addr_i=0x80, wdata_i=0xCAFEF00D) -> mem_we_o=1, mem_wdata_o=0xCAFEF00D; stall_o high 2 cycles; rdata_o unchanged from previous load.
- Back-to-back load, load with MemRead_i held through DONE -> exactly two mem_req_o assertions; no re-issue in DONE; second request starts in the cycle after DONE.
- rst_i asserted in BUSY before ack, then a late ack after release -> all outputs 0 immediately; the late ack is ignored; state stays IDLE.
- MemRead_i=MemWrite_i=1 -> mem_we_o=1 (write issued).
- MEM_TIMEOUT_EN with TIMEOUT=8, never ack a load -> req drops after 8 BUSY cycles; err_o=1 and stays 1; rdata_o=0xDEADBEEF; one DONE cycle with stall_o=0. Without the macro -> stall_o stays high indefinitely and err_o=0.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: multi-cycle data-memory access controller for the MEM stage.
//
// Turns a MemRead/MemWrite request from EX/MEM into a registered req/ack
// transaction to the data memory. It returns load data to MEM/WB and stalls the
// whole pipeline until the access completes.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   MemRead_i    load request from EX/MEM
//   MemWrite_i   store request from EX/MEM (wins over MemRead_i)
//   addr_i       byte address (ALU result)
//   wdata_i      store data
//   rdata_o      last completed load value, to MEM/WB
//   stall_o      freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB
//   mem_req_o    registered memory request
//   mem_we_o     registered write enable (1 = write)
//   mem_addr_o   registered request address
//   mem_wdata_o  registered write data
//   mem_ack_i    one-cycle completion pulse from memory
//   mem_rdata_i  read data, valid with mem_ack_i
//   err_o        sticky timeout error
//
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT
// cycles without ack. Without it err_o is tied low and BUSY waits forever.
module mem_stall_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              acc;
  logic              timeout;

  assign acc = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Fires on the edge that ends the TIMEOUT-th BUSY cycle; a same-cycle ack wins.
  assign timeout = (state_q == StBusy) && !mem_ack_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StBusy) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;  // zero on entry to BUSY
    end
  end

  assign err_d = err_q | timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Combinational so EX/MEM holds the instruction at the coming edge.
        stall_o = acc && !rst_i;
        if (acc) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = MemWrite_i;
          req_d   = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = StDone;
        end else if (timeout) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = DATA_W'(32'hDEADBEEF);
          state_d = StDone;
        end
      end
      StDone: begin
        // One unstalled cycle; the same instruction is still visible, so no re-issue.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: inputs are driven 1 ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_mem_stall_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          MemRead_i, MemWrite_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_o;
  logic          stall_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  int req_rises = 0;
  int base;
  logic req_prev = 1'b0;

  mem_stall_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts request assertions (rising edges of mem_req_o).
  always @(negedge clk_i) begin
    if (mem_req_o && !req_prev) req_rises++;
    req_prev = mem_req_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    tick(); tick();
    smp();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    tick(); rst_i = 1'b0;
    tick();

    // Load, ack in cycle 3: stall in cycles 0..3, DONE in cycle 4
    MemRead_i = 1'b1; addr_i = 32'h40;
    smp(); chk("ld_c0_stall", stall_o, 1); chk("ld_c0_req", mem_req_o, 0);
    tick(); smp();
    chk("ld_c1_req", mem_req_o, 1); chk("ld_c1_we", mem_we_o, 0);
    chk("ld_c1_addr", mem_addr_o, 32'h40); chk("ld_c1_stall", stall_o, 1);
    tick(); smp();
    chk("ld_c2_addr", mem_addr_o, 32'h40); chk("ld_c2_stall", stall_o, 1);
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    smp(); chk("ld_c3_stall", stall_o, 1); chk("ld_c3_addr", mem_addr_o, 32'h40);
    tick(); mem_ack_i = 1'b0; mem_rdata_i = '0;
    smp();
    chk("ld_done_stall", stall_o, 0); chk("ld_done_req", mem_req_o, 0);
    chk("ld_done_rdata", rdata_o, 32'h12345678);
    tick(); MemRead_i = 1'b0;
    smp(); chk("ld_idle_stall", stall_o, 0); chk("ld_idle_req", mem_req_o, 0);

    // Store, immediate ack
    tick(); MemWrite_i = 1'b1; addr_i = 32'h80; wdata_i = 32'hCAFEF00D;
    smp(); chk("st_c0_stall", stall_o, 1);
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'hBAADBAAD;
    smp();
    chk("st_c1_req", mem_req_o, 1); chk("st_c1_we", mem_we_o, 1);
    chk("st_c1_wdata", mem_wdata_o, 32'hCAFEF00D); chk("st_c1_addr", mem_addr_o, 32'h80);
    chk("st_c1_stall", stall_o, 1);
    tick(); mem_ack_i = 1'b0;
    smp();
    chk("st_done_stall", stall_o, 0); chk("st_done_req", mem_req_o, 0);
    chk("st_rdata_kept", rdata_o, 32'h12345678);
    tick(); MemWrite_i = 1'b0;
    smp(); chk("st_idle_stall", stall_o, 0); chk("st_idle_req", mem_req_o, 0);

    // Back-to-back loads, MemRead held through DONE
    base = req_rises;
    tick(); MemRead_i = 1'b1; addr_i = 32'h100;
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    tick(); mem_ack_i = 1'b0;
    smp();
    chk("b2b_done1_req", mem_req_o, 0); chk("b2b_done1_stall", stall_o, 0);
    chk("b2b_done1_rdata", rdata_o, 32'h11111111);
    tick(); addr_i = 32'h104;
    smp(); chk("b2b_idle_stall", stall_o, 1); chk("b2b_idle_req", mem_req_o, 0);
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
    smp(); chk("b2b_c1_req", mem_req_o, 1); chk("b2b_c1_addr", mem_addr_o, 32'h104);
    tick(); mem_ack_i = 1'b0; MemRead_i = 1'b0;
    smp(); chk("b2b_done2_rdata", rdata_o, 32'h22222222); chk("b2b_done2_stall", stall_o, 0);
    tick(); tick();
    chk("b2b_req_count", req_rises - base, 2);

    // Reset during BUSY, then a late ack
    MemRead_i = 1'b1; addr_i = 32'h200;
    tick(); smp(); chk("rb_busy_req", mem_req_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rb_req", mem_req_o, 0); chk("rb_addr", mem_addr_o, 0);
    chk("rb_rdata", rdata_o, 0); chk("rb_stall", stall_o, 0); chk("rb_we", mem_we_o, 0);
    MemRead_i = 1'b0;
    tick(); rst_i = 1'b0;
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h33333333;
    smp(); chk("rb_late_req", mem_req_o, 0); chk("rb_late_stall", stall_o, 0);
    tick(); mem_ack_i = 1'b0;
    smp(); chk("rb_after_rdata", rdata_o, 0); chk("rb_after_stall", stall_o, 0);
    chk("rb_after_req", mem_req_o, 0);

    // MemRead and MemWrite together: write wins
    tick(); MemRead_i = 1'b1; MemWrite_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h55AA55AA;
    tick(); mem_ack_i = 1'b1; mem_rdata_i = 32'h44444444;
    smp(); chk("rw_we", mem_we_o, 1); chk("rw_req", mem_req_o, 1);
    chk("rw_wdata", mem_wdata_o, 32'h55AA55AA);
    tick(); mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    smp(); chk("rw_rdata_kept", rdata_o, 0); chk("rw_done_stall", stall_o, 0);
    tick();

    // Load that is never acked
    tick(); MemRead_i = 1'b1; addr_i = 32'h400;
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      tick(); smp();
      chk($sformatf("to_busy%0d_req", i), mem_req_o, 1);
      chk($sformatf("to_busy%0d_stall", i), stall_o, 1);
    end
    tick();
    smp();
    chk("to_done_req", mem_req_o, 0); chk("to_done_stall", stall_o, 0);
    chk("to_done_err", err_o, 1); chk("to_done_rdata", rdata_o, 32'hDEADBEEF);
    tick(); MemRead_i = 1'b0;
    tick(); tick();
    smp(); chk("to_err_sticky", err_o, 1); chk("to_idle_stall", stall_o, 0);
`else
    for (int i = 1; i <= 20; i++) begin
      tick(); smp();
      chk($sformatf("nt_busy%0d_stall", i), stall_o, 1);
      chk($sformatf("nt_busy%0d_req", i), mem_req_o, 1);
      chk($sformatf("nt_busy%0d_err", i), err_o, 0);
    end
    MemRead_i = 1'b0;
    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    smp(); chk("nt_rst_stall", stall_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
